fifo_ld_responder: RTL and testbench

// - Responder side of the FIFO load-request interface: accepts ld_req, tracks up to DEPTH outstanding loads, returns ld_resp.
// - Sits between the FIFO controller load unit (initiator) and the tile memory port.
// - Converts each ld_req into one 8B-aligned memory read tagged with its table index.
// - Extracts the addressed bytes from the returned word and returns them with the originating mshrid.

---
 rtl/fifo_ld_responder_if.sv | 39 +++
 rtl/fifo_ld_responder.sv | 111 +++++++++++
 tb/tb_fifo_ld_responder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ld_responder_if.sv
// fifo_ld_responder_if: load-request, load-response and memory-port signals of the FIFO load responder
interface fifo_ld_responder_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 40,
  parameter int DATA_W = 64
);
  localparam int TW = $clog2(DEPTH);
  logic              ld_req_valid;
  logic              ld_req_ready;
  logic [ADDR_W-1:0] ld_req_addr;
  logic [1:0]        ld_req_size;
  logic [7:0]        ld_req_mshrid;
  logic              ld_resp_valid;
  logic [7:0]        ld_resp_mshrid;
  logic [DATA_W-1:0] ld_resp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [TW-1:0]     mem_req_tag;
  logic              mem_resp_valid;
  logic [TW-1:0]     mem_resp_tag;
  logic [DATA_W-1:0] mem_resp_data;
  modport slave (
    input  ld_req_valid, ld_req_addr, ld_req_size, ld_req_mshrid,
    output ld_req_ready,
    output ld_resp_valid, ld_resp_mshrid, ld_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_tag,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_tag, mem_resp_data
  );
  modport master (
    output ld_req_valid, ld_req_addr, ld_req_size, ld_req_mshrid,
    input  ld_req_ready,
    input  ld_resp_valid, ld_resp_mshrid, ld_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_tag,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_tag, mem_resp_data
  );
endinterface

// File: rtl/fifo_ld_responder.sv
// fifo_ld_responder: tracks up to DEPTH outstanding loads, issues aligned 8B reads, returns extracted bytes; FIFO_LD_RESP_CNT_EN adds a completed-load counter
module fifo_ld_responder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 40,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  fifo_ld_responder_if.slave  io_ld,
  output logic                stray_o,
  output logic [31:0]         ld_cnt_o
);
  localparam int TW = $clog2(DEPTH);
  logic [DEPTH-1:0]  r_v;
  logic [7:0]        r_mshrid [DEPTH];
  logic [1:0]        r_size   [DEPTH];
  logic [2:0]        r_off    [DEPTH];
  logic              r_iss_v;
  logic [ADDR_W-1:0] r_iss_addr;
  logic [TW-1:0]     r_iss_tag;
  logic              r_resp_v;
  logic [7:0]        r_resp_mshrid;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_stray;
  logic [TW-1:0]     w_idx;
  logic              w_ready;
  logic              w_fire;
  logic              w_hit;
  logic [1:0]        w_sz;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_mask;
  assign w_ready = ~&r_v && (!r_iss_v || io_ld.mem_req_ready);
  assign w_fire  = io_ld.ld_req_valid && w_ready;
  assign w_hit   = io_ld.mem_resp_valid && r_v[io_ld.mem_resp_tag];
  assign w_sz    = r_size[io_ld.mem_resp_tag];
  assign w_shift = io_ld.mem_resp_data >> {r_off[io_ld.mem_resp_tag], 3'b000};
  assign w_mask  = {{32{w_sz == 2'd3}}, {16{w_sz[1]}}, {8{|w_sz}}, 8'hFF};
  // lowest-index free entry; frees landing this cycle are not yet visible here
  always_comb begin
    w_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) w_idx = r_v[i] ? w_idx : TW'(i);
  end
  // outstanding-load table: free on a matching return, fill on request accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mshrid[i] <= '0;
        r_size[i]   <= '0;
        r_off[i]    <= '0;
      end
    end else begin
      if (w_hit) r_v[io_ld.mem_resp_tag] <= 1'b0;
      if (w_fire) begin
        r_v[w_idx]      <= 1'b1;
        r_mshrid[w_idx] <= io_ld.ld_req_mshrid;
        r_size[w_idx]   <= io_ld.ld_req_size;
        r_off[w_idx]    <= io_ld.ld_req_addr[2:0];
      end
    end
  end
  // single-slot issue register, held until the memory port accepts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_v    <= 1'b0;
      r_iss_addr <= '0;
      r_iss_tag  <= '0;
    end else if (w_fire) begin
      r_iss_v    <= 1'b1;
      r_iss_addr <= {io_ld.ld_req_addr[ADDR_W-1:3], 3'b000};
      r_iss_tag  <= w_idx;
    end else if (io_ld.mem_req_ready) begin
      r_iss_v    <= 1'b0;
    end
  end
  // registered load response and sticky flag for returns on unallocated tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_v      <= 1'b0;
      r_resp_mshrid <= '0;
      r_resp_data   <= '0;
      r_stray       <= 1'b0;
    end else begin
      r_resp_v <= w_hit;
      r_stray  <= r_stray || (io_ld.mem_resp_valid && !r_v[io_ld.mem_resp_tag]);
      if (w_hit) begin
        r_resp_mshrid <= r_mshrid[io_ld.mem_resp_tag];
        r_resp_data   <= w_shift & w_mask;
      end
    end
  end
`ifdef FIFO_LD_RESP_CNT_EN
  logic [31:0] r_cnt;
  // completed-load counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= r_cnt + 32'(r_resp_v);
  end
  assign ld_cnt_o = r_cnt;
`else
  assign ld_cnt_o = '0;
`endif
  assign io_ld.ld_req_ready   = w_ready;
  assign io_ld.mem_req_valid  = r_iss_v;
  assign io_ld.mem_req_addr   = r_iss_addr;
  assign io_ld.mem_req_tag    = r_iss_tag;
  assign io_ld.ld_resp_valid  = r_resp_v;
  assign io_ld.ld_resp_mshrid = r_resp_mshrid;
  assign io_ld.ld_resp_data   = r_resp_data;
  assign stray_o              = r_stray;
endmodule

// File: tb/tb_fifo_ld_responder.sv
// tb_fifo_ld_responder: directed and randomized checks of fifo_ld_responder against a transaction-level model
module tb_fifo_ld_responder;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stray_o;
  logic [31:0] ld_cnt_o;
  int n_cmp = 0;
  int n_err = 0;
  fifo_ld_responder_if #(.DEPTH(DEPTH), .ADDR_W(40), .DATA_W(64)) ifc ();
  fifo_ld_responder #(.DEPTH(DEPTH), .ADDR_W(40), .DATA_W(64)) dut (
    .clk(clk), .rst(rst), .io_ld(ifc.slave), .stray_o(stray_o), .ld_cnt_o(ld_cnt_o)
  );
  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", t, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] extract(input logic [63:0] w, input logic [2:0] off, input logic [1:0] s);
    logic [63:0] r = '0;
    for (int b = 0; b < (1 << s); b++)
      if (int'(off) + b < 8) r[8*b +: 8] = w[8*(int'(off) + b) +: 8];
    return r;
  endfunction

  // transaction-level model: who holds which tag, what is waiting to issue, what must come back
  bit          m_busy [DEPTH];
  logic [7:0]  m_mshrid [DEPTH];
  logic [2:0]  m_off [DEPTH];
  logic [1:0]  m_size [DEPTH];
  logic [39:0] iss_addr_q[$];
  logic [1:0]  iss_tag_q[$];
  bit          rp_v = 0;
  logic [7:0]  rp_mshrid;
  logic [63:0] rp_data;
  bit          exp_stray = 0;
  int          exp_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      iss_addr_q.delete();
      iss_tag_q.delete();
      rp_v = 0;
      exp_stray = 0;
      exp_cnt = 0;
    end else begin
      int fi;
      bit any_free;
      fi = -1;
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_busy[i]) fi = i;
      any_free = fi >= 0;
      chk("mem_req_valid", ifc.mem_req_valid, iss_tag_q.size() != 0);
      if (iss_tag_q.size() != 0) begin
        chk("mem_req_addr", ifc.mem_req_addr, iss_addr_q[0]);
        chk("mem_req_tag", ifc.mem_req_tag, iss_tag_q[0]);
      end
      chk("ld_resp_valid", ifc.ld_resp_valid, rp_v);
      if (rp_v) begin
        chk("ld_resp_mshrid", ifc.ld_resp_mshrid, rp_mshrid);
        chk("ld_resp_data", ifc.ld_resp_data, rp_data);
      end
      chk("stray_o", stray_o, exp_stray);
      chk("ld_cnt_o", ld_cnt_o, exp_cnt);
      chk("ld_req_ready", ifc.ld_req_ready, any_free && (iss_tag_q.size() == 0 || ifc.mem_req_ready));
`ifdef FIFO_LD_RESP_CNT_EN
      if (rp_v) exp_cnt++;
`endif
      if (iss_tag_q.size() != 0 && ifc.mem_req_ready) begin
        void'(iss_addr_q.pop_front());
        void'(iss_tag_q.pop_front());
      end
      rp_v = 0;
      if (ifc.mem_resp_valid) begin
        if (m_busy[ifc.mem_resp_tag]) begin
          rp_v = 1;
          rp_mshrid = m_mshrid[ifc.mem_resp_tag];
          rp_data = extract(ifc.mem_resp_data, m_off[ifc.mem_resp_tag], m_size[ifc.mem_resp_tag]);
          m_busy[ifc.mem_resp_tag] = 0;
        end else exp_stray = 1;
      end
      if (ifc.ld_req_valid && ifc.ld_req_ready && any_free) begin
        m_busy[fi] = 1;
        m_mshrid[fi] = ifc.ld_req_mshrid;
        m_off[fi] = ifc.ld_req_addr[2:0];
        m_size[fi] = ifc.ld_req_size;
        iss_addr_q.push_back({ifc.ld_req_addr[39:3], 3'b000});
        iss_tag_q.push_back(2'(fi));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [39:0] a, input logic [1:0] s, input logic [7:0] m);
    bit acc = 0;
    int n = 0;
    ifc.ld_req_valid = 1;
    ifc.ld_req_addr = a;
    ifc.ld_req_size = s;
    ifc.ld_req_mshrid = m;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ifc.ld_req_ready;
      tick();
      n++;
    end
    ifc.ld_req_valid = 0;
    chk("ld_accept", acc, 1);
  endtask

  task automatic mresp(input logic [1:0] t, input logic [63:0] d);
    ifc.mem_resp_valid = 1;
    ifc.mem_resp_tag = t;
    ifc.mem_resp_data = d;
    tick();
    ifc.mem_resp_valid = 0;
  endtask

  initial begin
    logic [1:0] bl[$];
    ifc.ld_req_valid = 0; ifc.ld_req_addr = '0; ifc.ld_req_size = '0; ifc.ld_req_mshrid = '0;
    ifc.mem_req_ready = 1; ifc.mem_resp_valid = 0; ifc.mem_resp_tag = '0; ifc.mem_resp_data = '0;
    tick(); tick();
    chk("rst_mem_req_valid", ifc.mem_req_valid, 0);
    chk("rst_mem_req_addr", ifc.mem_req_addr, 0);
    chk("rst_mem_req_tag", ifc.mem_req_tag, 0);
    chk("rst_ld_resp_valid", ifc.ld_resp_valid, 0);
    chk("rst_ld_resp_mshrid", ifc.ld_resp_mshrid, 0);
    chk("rst_ld_resp_data", ifc.ld_resp_data, 0);
    chk("rst_stray", stray_o, 0);
    chk("rst_cnt", ld_cnt_o, 0);
    rst = 0;
    tick();
    ld(40'h1000, 2'd3, 8'd145);
    chk("single_req_addr", ifc.mem_req_addr, 40'h1000);
    chk("single_req_tag", ifc.mem_req_tag, 0);
    tick(); tick();
    mresp(2'd0, 64'h1122334455667788);
    chk("single_resp_valid", ifc.ld_resp_valid, 1);
    chk("single_resp_mshrid", ifc.ld_resp_mshrid, 145);
    chk("single_resp_data", ifc.ld_resp_data, 64'h1122334455667788);
    ld(40'h1006, 2'd1, 8'd7);
    chk("h_req_addr", ifc.mem_req_addr, 40'h1000);
    mresp(2'd0, 64'hAABBCCDD11223344);
    chk("h_resp_data", ifc.ld_resp_data, 64'h000000000000AABB);
    ld(40'h1004, 2'd2, 8'd8);
    mresp(2'd0, 64'hAABBCCDD11223344);
    chk("w_resp_data", ifc.ld_resp_data, 64'h00000000AABBCCDD);
    ld(40'h1007, 2'd2, 8'd9);
    mresp(2'd0, 64'hAABBCCDD11223344);
    chk("mis_resp_data", ifc.ld_resp_data, 64'h00000000000000AA);
    for (int i = 0; i < 4; i++) ld(40'h2000 + 40'(8 * i), 2'd3, 8'(10 + i));
    @(negedge clk);
    chk("full_ready", ifc.ld_req_ready, 0);
    tick();
    mresp(2'd2, 64'h5555);
    @(negedge clk);
    chk("free_ready", ifc.ld_req_ready, 1);
    tick();
    ld(40'h3000, 2'd3, 8'd14);
    chk("realloc_tag", ifc.mem_req_tag, 2);
    mresp(2'd0, 64'h1); mresp(2'd1, 64'h2); mresp(2'd3, 64'h3); mresp(2'd2, 64'h4);
    ld(40'h4000, 2'd0, 8'd1); ld(40'h4008, 2'd0, 8'd2); ld(40'h4010, 2'd0, 8'd3);
    mresp(2'd2, 64'h33);
    chk("ooo_1", ifc.ld_resp_mshrid, 3);
    mresp(2'd0, 64'h11);
    chk("ooo_2", ifc.ld_resp_mshrid, 1);
    mresp(2'd1, 64'h22);
    chk("ooo_3", ifc.ld_resp_mshrid, 2);
    ifc.mem_req_ready = 0;
    ld(40'h5008, 2'd3, 8'd40);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", ifc.mem_req_valid, 1);
      chk("hold_addr", ifc.mem_req_addr, 40'h5008);
      chk("hold_tag", ifc.mem_req_tag, 0);
      chk("hold_ready", ifc.ld_req_ready, 0);
      tick();
    end
    ifc.mem_req_ready = 1;
    tick();
    mresp(2'd0, 64'h77);
    tick();
    mresp(2'd3, 64'h99);
    chk("stray_no_resp", ifc.ld_resp_valid, 0);
    chk("stray_set", stray_o, 1);
    ld(40'h6000, 2'd3, 8'd50);
    ld(40'h6008, 2'd3, 8'd51);
    #2 rst = 1;
    #1 chk("async_mem_req_valid", ifc.mem_req_valid, 0);
    tick();
    rst = 0;
    tick();
    mresp(2'd0, 64'hA);
    chk("rst_ret0_resp", ifc.ld_resp_valid, 0);
    mresp(2'd1, 64'hB);
    chk("rst_ret1_resp", ifc.ld_resp_valid, 0);
    chk("rst_ret_stray", stray_o, 1);
    for (int i = 0; i < 6; i++) begin
      ld(40'h7000 + 40'(i), 2'(i % 4), 8'(60 + i));
      mresp(2'd0, 64'h0123456789ABCDEF);
    end
    tick();
`ifdef FIFO_LD_RESP_CNT_EN
    chk("cnt_six", ld_cnt_o, 6);
`else
    chk("cnt_six", ld_cnt_o, 0);
`endif
    for (int c = 0; c < 600; c++) begin
      ifc.ld_req_valid = $urandom_range(0, 1) == 1;
      ifc.ld_req_addr = {8'($urandom), $urandom};
      ifc.ld_req_size = 2'($urandom);
      ifc.ld_req_mshrid = 8'($urandom);
      ifc.mem_req_ready = $urandom_range(0, 3) != 0;
      bl.delete();
      for (int i = 0; i < DEPTH; i++) if (m_busy[i]) bl.push_back(2'(i));
      ifc.mem_resp_data = {$urandom, $urandom};
      ifc.mem_resp_valid = 0;
      if (bl.size() != 0 && $urandom_range(0, 2) == 0) begin
        ifc.mem_resp_valid = 1;
        ifc.mem_resp_tag = bl[$urandom_range(0, bl.size() - 1)];
      end else if ($urandom_range(0, 39) == 0) begin
        ifc.mem_resp_valid = 1;
        ifc.mem_resp_tag = 2'($urandom);
      end
      tick();
    end
    ifc.ld_req_valid = 0;
    ifc.mem_resp_valid = 0;
    ifc.mem_req_ready = 1;
    tick(); tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
